// File: rtl/img_pkg.sv
// img_pkg: shared pixel width, line count and read-FSM states for the line buffer slice.
package img_pkg;
  localparam int PIX_W = 8;
  localparam int NUM_LINES = 4;
  typedef enum logic {IDLE, READ} rd_state_e;
endpackage

// File: rtl/lb_ram.sv
// lb_ram: one line buffer, single write port plus registered read-first read port.
module lb_ram
  import img_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // Read register holds its value between bursts; reset zeroes only this register.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: four rotating line buffers streaming aligned columns to the 3x3 row muxes.
// Define LB_OVERFLOW_FLAG_EN to add the sticky o_overflow output.
module line_buffer_ctrl
  import img_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int COL_W = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_valid,
  output logic             o_pixel_ready,
  output logic [PIX_W-1:0] o_lb_data0,
  output logic [PIX_W-1:0] o_lb_data1,
  output logic [PIX_W-1:0] o_lb_data2,
  output logic [PIX_W-1:0] o_lb_data3,
  output logic [1:0]       o_rd_sel,
  output logic             o_rd_valid,
`ifdef LB_OVERFLOW_FLAG_EN
  output logic             o_overflow,
`endif
  output logic             o_line_done
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [1:0]       wr_line_q, wr_line_d, rd_line_q, rd_line_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  rd_state_e        state_q, state_d;
  logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, line_done_q, line_done_d;
  logic             wr_en, wr_last, rd_en;
  logic [PIX_W-1:0] lb_data [NUM_LINES];
  assign o_pixel_ready = fill_cnt_q != 3'd4;
  assign wr_en = i_pixel_valid & o_pixel_ready;
  assign wr_last = wr_en & (wr_col_q == COL_LAST);
  assign rd_en = state_q == READ;
  // fill_cnt_d already folds in this cycle's completion and release, so a burst
  // may start the cycle after the line completes; the rd_last_q cycle is blocked
  // because the finishing burst has not yet released its line.
  always_comb begin
    wr_col_d = wr_en ? (wr_last ? '0 : wr_col_q + 1'b1) : wr_col_q;
    wr_line_d = wr_line_q + {1'b0, wr_last};
    fill_cnt_d = fill_cnt_q + {2'b0, wr_last} - {2'b0, line_done_q};
    rd_line_d = rd_line_q + {1'b0, line_done_q};
    rd_last_d = rd_en && (rd_col_q == COL_LAST);
    rd_col_d = rd_en ? rd_col_q + 1'b1 : '0;
    state_d = rd_en ? (rd_last_d ? IDLE : READ) : ((fill_cnt_d >= 3'd3) && !rd_last_q ? READ : IDLE);
    rd_valid_d = rd_en;
    line_done_d = rd_last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col_q <= '0;
      wr_line_q <= '0;
      rd_col_q <= '0;
      rd_line_q <= '0;
      fill_cnt_q <= '0;
      state_q <= IDLE;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      wr_col_q <= wr_col_d;
      wr_line_q <= wr_line_d;
      rd_col_q <= rd_col_d;
      rd_line_q <= rd_line_d;
      fill_cnt_q <= fill_cnt_d;
      state_q <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
      line_done_q <= line_done_d;
    end
  end
  for (genvar n = 0; n < NUM_LINES; n++) begin : g_lb
    lb_ram #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en && (wr_line_q == 2'(n))),
      .waddr (wr_col_q),
      .wdata (i_pixel_data),
      .re    (rd_en),
      .raddr (rd_col_q),
      .rdata (lb_data[n])
    );
  end
  assign o_lb_data0 = lb_data[0];
  assign o_lb_data1 = lb_data[1];
  assign o_lb_data2 = lb_data[2];
  assign o_lb_data3 = lb_data[3];
  assign o_rd_sel = rd_line_q;
  assign o_rd_valid = rd_valid_q;
  assign o_line_done = line_done_q;
`ifdef LB_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;
  always_comb overflow_d = overflow_q | (i_pixel_valid & ~o_pixel_ready);
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else overflow_q <= overflow_d;
  end
  assign o_overflow = overflow_q;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed tables plus random traffic against a pixel-index reference model.
module tb_line_buffer_ctrl;
  localparam int W = 8;
  logic clk = 0, rst = 1, i_pixel_valid = 0;
  logic [7:0] i_pixel_data = 0;
  logic o_pixel_ready, o_rd_valid, o_line_done;
  logic [7:0] o_lb_data0, o_lb_data1, o_lb_data2, o_lb_data3;
  logic [1:0] o_rd_sel;
`ifdef LB_OVERFLOW_FLAG_EN
  logic o_overflow;
`endif
  always #5 clk = ~clk;
  line_buffer_ctrl #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid),
    .o_pixel_ready(o_pixel_ready), .o_lb_data0(o_lb_data0), .o_lb_data1(o_lb_data1),
    .o_lb_data2(o_lb_data2), .o_lb_data3(o_lb_data3), .o_rd_sel(o_rd_sel),
    .o_rd_valid(o_rd_valid),
`ifdef LB_OVERFLOW_FLAG_EN
    .o_overflow(o_overflow),
`endif
    .o_line_done(o_line_done)
  );
  int errs = 0, chks = 0, done_total = 0;
  bit chk_on = 0;
  task automatic chk(input string nm, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: pixels tracked by stream index, burst by a cycle timer
  // (0..W-1 issuing, W last data shown, W+1 line_done shown, -1 idle).
  logic [7:0] mem [4][W];
  bit mw [4][W];
  logic [7:0] m_data [4];
  bit m_dk [4];
  int m_idx, m_fill, m_bt = -1, m_sel, m_fn;
  bit m_ovf, m_wr, m_compl, m_done;
  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_fill = 0; m_bt = -1; m_sel = 0; m_ovf = 0;
      for (int k = 0; k < 4; k++) begin m_data[k] = 0; m_dk[k] = 1; end
    end else begin
      m_wr = i_pixel_valid && m_fill != 4;
      if (i_pixel_valid && m_fill == 4) m_ovf = 1;
      m_compl = m_wr && (m_idx % W == W - 1);
      m_done = m_bt == W + 1;
      if (m_bt >= 0 && m_bt < W)
        for (int k = 0; k < 4; k++) begin m_data[k] = mem[k][m_bt]; m_dk[k] = mw[k][m_bt]; end
      if (m_wr) begin
        mem[(m_idx / W) % 4][m_idx % W] = i_pixel_data;
        mw[(m_idx / W) % 4][m_idx % W] = 1;
        m_idx++;
      end
      m_fn = m_fill + int'(m_compl) - int'(m_done);
      m_sel = (m_sel + int'(m_done)) % 4;
      m_bt = (m_bt >= 0 && m_bt <= W) ? m_bt + 1 : (m_fn >= 3 ? 0 : -1);
      m_fill = m_fn;
    end
  end
  always @(negedge clk) begin
    if (o_line_done) done_total++;
    if (chk_on) begin
      chk("ready", int'(o_pixel_ready), int'(m_fill != 4));
      chk("rd_valid", int'(o_rd_valid), int'(m_bt >= 1 && m_bt <= W));
      chk("line_done", int'(o_line_done), int'(m_bt == W + 1));
      chk("rd_sel", int'(o_rd_sel), m_sel);
      if (m_dk[0]) chk("data0", int'(o_lb_data0), int'(m_data[0]));
      if (m_dk[1]) chk("data1", int'(o_lb_data1), int'(m_data[1]));
      if (m_dk[2]) chk("data2", int'(o_lb_data2), int'(m_data[2]));
      if (m_dk[3]) chk("data3", int'(o_lb_data3), int'(m_data[3]));
`ifdef LB_OVERFLOW_FLAG_EN
      chk("overflow", int'(o_overflow), int'(m_ovf));
`endif
    end
  end
  typedef struct {int d0; int d1; int d2; int sel;} vec_t;
  vec_t tbl [W];
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    i_pixel_valid = v;
    i_pixel_data = d;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    i_pixel_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic send(input logic [7:0] d);
    drive(1, d);
    for (int n = 0; n < 100 && !o_pixel_ready; n++) @(negedge clk);
    if (!o_pixel_ready) chk("send_timeout", 0, 1);
  endtask
  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!o_rd_valid && n < 60) begin drive(0, 0); n++; end
    if (!o_rd_valid) chk(nm, 0, 1);
  endtask
  task automatic check_burst(input string nm, input int base);
    int n;
    wait_valid({nm, "_timeout"}, n);
    for (int c = 0; c < W; c++) begin
      chk({nm, "_valid"}, int'(o_rd_valid), 1);
      chk({nm, "_d0"}, int'(o_lb_data0), base + tbl[c].d0);
      chk({nm, "_d1"}, int'(o_lb_data1), base + tbl[c].d1);
      chk({nm, "_d2"}, int'(o_lb_data2), base + tbl[c].d2);
      chk({nm, "_sel"}, int'(o_rd_sel), tbl[c].sel);
      drive(0, 0);
    end
    chk({nm, "_done"}, int'(o_line_done), 1);
    drive(0, 0);
    chk({nm, "_sel_next"}, int'(o_rd_sel), 1);
  endtask
  initial begin
    int n, snap;
    for (int c = 0; c < W; c++) tbl[c] = '{c, W + c, 2 * W + c, 0};
    do_reset();
    chk_on = 1;
    chk("rst_ready", int'(o_pixel_ready), 1);
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_done", int'(o_line_done), 0);
    chk("rst_sel", int'(o_rd_sel), 0);
    chk("rst_d0", int'(o_lb_data0), 0);
    for (int i = 0; i < 3 * W; i++) drive(1, 8'(i));
    wait_valid("first_timeout", n);
    chk("first_latency", n, 2);
    check_burst("first", 0);
    do_reset();
    snap = done_total;
    for (int i = 0; i < 8 * W; i++) send(8'($urandom));
    drive(0, 0);
    repeat (60) drive(0, 0);
    chk("stream_bursts", done_total - snap, 6);
    chk("stream_sel", int'(o_rd_sel), 2);
    do_reset();
    for (int i = 0; i < 4 * W; i++) drive(1, 8'(i));
    drive(1, 8'(4 * W));
    chk("full_ready", int'(o_pixel_ready), 0);
    drive(0, 0);
`ifdef LB_OVERFLOW_FLAG_EN
    chk("ovf_set", int'(o_overflow), 1);
    repeat (30) drive(0, 0);
    chk("ovf_sticky", int'(o_overflow), 1);
`else
    repeat (30) drive(0, 0);
`endif
    do_reset();
    for (int i = 0; i < 3 * W; i++) drive(1, 8'(i));
    drive(0, 0);
    drive(0, 0);
    for (int i = 0; i < W; i++) drive(1, 8'(3 * W + i));
    chk("coll_done", int'(o_line_done), 1);
    drive(0, 0);
    chk("coll_ready", int'(o_pixel_ready), 1);
    chk("coll_valid0", int'(o_rd_valid), 0);
    chk("coll_sel", int'(o_rd_sel), 1);
    drive(0, 0);
    chk("coll_valid1", int'(o_rd_valid), 1);
    repeat (20) drive(0, 0);
    do_reset();
    for (int i = 0; i < 3 * W; i++) drive(1, 8'(i));
    wait_valid("mid_timeout", n);
    repeat (4) drive(0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_valid", int'(o_rd_valid), 0);
    chk("mid_ready", int'(o_pixel_ready), 1);
    chk("mid_d0", int'(o_lb_data0), 0);
    for (int i = 0; i < 3 * W; i++) drive(1, 8'(100 + i));
    check_burst("after_rst", 100);
    do_reset();
    for (int i = 0; i < 3 * W; i++) begin drive(1, 8'(i)); drive(0, 0); drive(0, 0); end
    check_burst("gaps", 0);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      i_pixel_valid = $urandom_range(0, 3) != 0;
      i_pixel_data = 8'($urandom);
    end
    @(negedge clk);
    rst = 0;
    i_pixel_valid = 0;
    repeat (40) drive(0, 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
